// File: rtl/hq_cmac_pkg.sv
// hq_cmac_pkg: shared state encoding, default number format and saturation bounds
package hq_cmac_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;
    localparam int DEF_DW = 16;
    localparam int DEF_FRAC = 8;
    function automatic longint sat_hi(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction
    function automatic longint sat_lo(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction
endpackage

// File: rtl/hq_cmac_engine_cmul.sv
// hq_cmul_stage: registered complex multiply, full-precision products shifted down by FRAC
module hq_cmul_stage
    import hq_cmac_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int FRAC = DEF_FRAC,
    parameter int AW = DW + 4
) (
    input logic clk,
    input logic rst,
    input logic en,
    input logic signed [DW-1:0] a_r,
    input logic signed [DW-1:0] a_i,
    input logic signed [DW-1:0] b_r,
    input logic signed [DW-1:0] b_i,
    output logic signed [AW-1:0] p_r,
    output logic signed [AW-1:0] p_i
);
    localparam int PW = 2 * DW + 1;
    logic signed [PW-1:0] ar, ai, br, bi;
    logic signed [AW-1:0] m_r, m_i;
    assign ar = PW'(a_r);
    assign ai = PW'(a_i);
    assign br = PW'(b_r);
    assign bi = PW'(b_i);
    // arithmetic shift on the full-width result gives floor rounding
    assign m_r = AW'((ar * br - ai * bi) >>> FRAC);
    assign m_i = AW'((ar * bi + ai * br) >>> FRAC);
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r <= '0;
            p_i <= '0;
        end else if (en) begin
            p_r <= m_r;
            p_i <= m_i;
        end
    end
endmodule

// File: rtl/hq_cmac_engine.sv
// hq_cmac_engine: batched complex MAC producing NCOL dot products of NT terms each
module hq_cmac_engine
    import hq_cmac_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int FRAC = DEF_FRAC,
    parameter int NT = 2,
    parameter int NCOL = 4,
    parameter int SAT = 1
) (
    input logic clk,
    input logic rst,
    input logic start,
    input logic in_valid,
    output logic in_ready,
    input logic signed [DW-1:0] a_r,
    input logic signed [DW-1:0] a_i,
    input logic signed [DW-1:0] b_r,
    input logic signed [DW-1:0] b_i,
    output logic out_valid,
    input logic out_ready,
    output logic [NCOL*DW-1:0] out_r,
    output logic [NCOL*DW-1:0] out_i,
    output logic busy,
    output logic done
);
    localparam int AW = DW + 4;
    localparam int TW = NT > 1 ? $clog2(NT) : 1;
    localparam int SW = NCOL > 1 ? $clog2(NCOL) : 1;
    localparam logic signed [AW-1:0] HI = AW'(sat_hi(DW));
    localparam logic signed [AW-1:0] LO = AW'(sat_lo(DW));
    state_t state, state_n;
    logic [TW-1:0] term;
    logic [SW-1:0] slot, p_slot, a_slot;
    logic accept, p_vld, p_first, p_last, a_wr, last_wr;
    logic signed [AW-1:0] p_r, p_i, acc_r, acc_i;
    logic [DW-1:0] w_r, w_i;

    assign accept = in_valid && in_ready;

    hq_cmul_stage #(.DW(DW), .FRAC(FRAC), .AW(AW)) u_cmul (
        .clk(clk), .rst(rst), .en(accept),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
        .p_r(p_r), .p_i(p_i)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = start ? ACCUM : IDLE;
            ACCUM: state_n = accept && term == TW'(NT - 1) && slot == SW'(NCOL - 1) ? DRAIN : ACCUM;
            DRAIN: state_n = last_wr ? OUT : DRAIN;
            OUT: state_n = out_ready ? IDLE : OUT;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready = state == ACCUM;
        out_valid = state == OUT;
        busy = state != IDLE;
    end

    // slot value as written: clamped to DW when saturating, otherwise the low DW bits
    assign w_r = SAT != 0 ? (acc_r > HI ? HI[DW-1:0] : acc_r < LO ? LO[DW-1:0] : acc_r[DW-1:0]) : acc_r[DW-1:0];
    assign w_i = SAT != 0 ? (acc_i > HI ? HI[DW-1:0] : acc_i < LO ? LO[DW-1:0] : acc_i[DW-1:0]) : acc_i[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            term <= '0;
            slot <= '0;
            p_vld <= 1'b0;
            p_first <= 1'b0;
            p_last <= 1'b0;
            p_slot <= '0;
            acc_r <= '0;
            acc_i <= '0;
            a_wr <= 1'b0;
            a_slot <= '0;
            last_wr <= 1'b0;
            out_r <= '0;
            out_i <= '0;
            done <= 1'b0;
        end else begin
            if (accept) begin
                term <= term == TW'(NT - 1) ? '0 : term + 1'b1;
                if (term == TW'(NT - 1)) slot <= slot == SW'(NCOL - 1) ? '0 : slot + 1'b1;
            end
            p_vld <= accept;
            p_first <= term == '0;
            p_last <= term == TW'(NT - 1);
            p_slot <= slot;
            if (p_vld) begin
                acc_r <= p_first ? p_r : acc_r + p_r;
                acc_i <= p_first ? p_i : acc_i + p_i;
            end
            a_wr <= p_vld && p_last;
            a_slot <= p_slot;
            if (a_wr) begin
                out_r[a_slot*DW +: DW] <= w_r;
                out_i[a_slot*DW +: DW] <= w_i;
            end
            last_wr <= a_wr && a_slot == SW'(NCOL - 1);
            done <= state == OUT && out_ready;
        end
    end
endmodule

// File: tb/tb_hq_cmac_engine.sv
// tb_hq_cmac_engine: directed and randomized checks of hq_cmac_engine against a behavioural model
module tb_hq_cmac_engine;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic start, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [15:0] a_r, a_i, b_r, b_i;
    logic [63:0] out_r, out_i;

    logic x_start, x_valid, x_oready;
    logic [15:0] xa_r, xa_i, xb_r, xb_i;
    logic w_rdy, w_ov, w_busy, w_done, s_rdy, s_ov, s_busy, s_done;
    logic [15:0] w_or, w_oi, s_or, s_oi;

    int total = 0, passed = 0, fails = 0;

    hq_cmac_engine #(.DW(16), .FRAC(8), .NT(2), .NCOL(4), .SAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i), .busy(busy), .done(done)
    );

    hq_cmac_engine #(.DW(16), .FRAC(8), .NT(2), .NCOL(1), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .start(x_start), .in_valid(x_valid), .in_ready(w_rdy),
        .a_r(xa_r), .a_i(xa_i), .b_r(xb_r), .b_i(xb_i), .out_valid(w_ov), .out_ready(x_oready),
        .out_r(w_or), .out_i(w_oi), .busy(w_busy), .done(w_done)
    );

    hq_cmac_engine #(.DW(16), .FRAC(8), .NT(2), .NCOL(1), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .start(x_start), .in_valid(x_valid), .in_ready(s_rdy),
        .a_r(xa_r), .a_i(xa_i), .b_r(xb_r), .b_i(xb_i), .out_valid(s_ov), .out_ready(x_oready),
        .out_r(s_or), .out_i(s_oi), .busy(s_busy), .done(s_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // complex product component, exact integer math floored by 2^FRAC
    function automatic longint prod(input logic [15:0] ar, ai, br, bi, input bit im);
        longint xr = longint'($signed(ar)), xi = longint'($signed(ai));
        longint yr = longint'($signed(br)), yi = longint'($signed(bi));
        return im ? (xr * yi + xi * yr) >>> 8 : (xr * yr - xi * yi) >>> 8;
    endfunction

    function automatic logic [15:0] sat16(input longint v);
        return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : 16'(v);
    endfunction

    function automatic logic [15:0] rnd();
        return 16'(int'($urandom_range(0, 4095)) - 2048);
    endfunction

    task automatic run1(input logic [15:0] ar0, ai0, br0, bi0, ar1, ai1, br1, bi1,
                        input logic [15:0] ew_r, ew_i, es_r, es_i);
        x_start = 1'b1;
        step;
        x_start = 1'b0;
        chk("one_ready", s_rdy, 1'b1);
        {xa_r, xa_i, xb_r, xb_i} = {ar0, ai0, br0, bi0};
        x_valid = 1'b1;
        step;
        {xa_r, xa_i, xb_r, xb_i} = {ar1, ai1, br1, bi1};
        step;
        x_valid = 1'b0;
        chk("lat0_ov", s_ov, 1'b0);
        step;
        chk("lat1_ov", s_ov, 1'b0);
        step;
        chk("lat2_ov", s_ov, 1'b0);
        chk("lat2_slot", s_or, es_r);
        step;
        chk("lat3_ov_sat", s_ov, 1'b1);
        chk("lat3_ov_wrap", w_ov, 1'b1);
        chk("sat_r", s_or, es_r);
        chk("sat_i", s_oi, es_i);
        chk("wrap_r", w_or, ew_r);
        chk("wrap_i", w_oi, ew_i);
        x_oready = 1'b1;
        step;
        x_oready = 1'b0;
        chk("one_done_sat", s_done, 1'b1);
        chk("one_done_wrap", w_done, 1'b1);
        chk("one_idle", s_busy, 1'b0);
        step;
        chk("one_done_drop", s_done, 1'b0);
    endtask

    task automatic run0(input bit stall, input bit hold);
        longint er[4], ei[4];
        logic [63:0] xr, xi;
        int n = 0, budget = 0;
        bit rdy, v;
        for (int k = 0; k < 4; k++) begin
            er[k] = 0;
            ei[k] = 0;
        end
        chk("idle_ready", in_ready, 1'b0);
        start = 1'b1;
        step;
        start = 1'b0;
        while (n < 8 && budget < 200) begin
            rdy = in_ready;
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            {a_r, a_i, b_r, b_i} = {rnd(), rnd(), rnd(), rnd()};
            in_valid = v;
            step;
            budget++;
            if (v && rdy) begin
                er[n / 2] += prod(a_r, a_i, b_r, b_i, 1'b0);
                ei[n / 2] += prod(a_r, a_i, b_r, b_i, 1'b1);
                n++;
            end
        end
        in_valid = 1'b0;
        chk("accept_count", n, 8);
        if (!stall) chk("b2b_cycles", budget, 8);
        for (int k = 0; k < 4; k++) begin
            xr[k*16 +: 16] = sat16(er[k]);
            xi[k*16 +: 16] = sat16(ei[k]);
        end
        budget = 0;
        while (!out_valid && budget < 20) begin
            chk("drain_ready", in_ready, 1'b0);
            step;
            budget++;
        end
        chk("out_valid_rise", out_valid, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("slot%0d_r", k), out_r[k*16 +: 16], xr[k*16 +: 16]);
            chk($sformatf("slot%0d_i", k), out_i[k*16 +: 16], xi[k*16 +: 16]);
        end
        if (hold) begin
            start = 1'b1;
            for (int c = 0; c < 10; c++) begin
                step;
                start = 1'b0;
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_r", out_r, xr);
                chk("hold_i", out_i, xi);
                chk("hold_done", done, 1'b0);
            end
        end
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("post_busy", busy, 1'b0);
        chk("post_valid", out_valid, 1'b0);
        step;
        chk("done_once", done, 1'b0);
        chk("no_restart", in_ready, 1'b0);
        chk("keep_r", out_r, xr);
        chk("keep_i", out_i, xi);
    endtask

    initial begin
        {start, in_valid, out_ready, a_r, a_i, b_r, b_i} = '0;
        {x_start, x_valid, x_oready, xa_r, xa_i, xb_r, xb_i} = '0;
        repeat (3) step;
        rst = 1'b0;
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_r", out_r, 64'h0);
        chk("rst_out_i", out_i, 64'h0);
        chk("rst_sat_busy", s_busy, 1'b0);

        run1(16'hffdd, 16'h00c1, 16'h0000, 16'h0000, 16'h0183, 16'hfff4, 16'h0100, 16'h0000,
             16'h0183, 16'hfff4, 16'h0183, 16'hfff4);
        run1(16'h7fff, 16'h0000, 16'h0100, 16'h0000, 16'h7fff, 16'h0000, 16'h0100, 16'h0000,
             16'hfffe, 16'h0000, 16'h7fff, 16'h0000);
        run1(16'h8000, 16'h0000, 16'h0100, 16'h0000, 16'h8000, 16'h0000, 16'h0100, 16'h0000,
             16'h0000, 16'h0000, 16'h8000, 16'h0000);

        run0(1'b0, 1'b0);
        run0(1'b1, 1'b0);
        run0(1'b1, 1'b1);

        // abort a batch after three pairs
        start = 1'b1;
        step;
        start = 1'b0;
        in_valid = 1'b1;
        for (int p = 0; p < 3; p++) begin
            {a_r, a_i, b_r, b_i} = {rnd(), rnd(), rnd(), rnd()};
            step;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("abort_ready", in_ready, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_out_r", out_r, 64'h0);
        chk("abort_out_i", out_i, 64'h0);
        for (int c = 0; c < 5; c++) begin
            step;
            chk("abort_quiet", {out_valid, done, busy}, 3'b000);
        end
        run0(1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
